// File: rtl/io_regfile_pkg.sv
// rtl/io_regfile_pkg.sv - shared defaults and effective-value select helper for io_regfile
package io_regfile_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_NIO   = 2;

   typedef logic [DEF_WIDTH-1:0] word_t;

   // True when register idx is an IO register whose pin is currently an input,
   // i.e. its effective value comes from the synchroniser rather than Q.
   function automatic logic io_input_mode(input int idx, input int nio, input logic [63:0] ctrl);
      return (idx >= 1) && (idx <= nio) && !ctrl[idx[5:0] - 6'd1];
   endfunction

endpackage

// File: rtl/io_sync2.sv
// rtl/io_sync2.sv - two-flop pin synchroniser with pending-change detect
module io_sync2
   import io_regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             change_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o      = s2_q;
   assign change_o = (s1_q != s2_q);

endmodule

// File: rtl/io_regfile.sv
// rtl/io_regfile.sv - register file with registered A/B reads, bypass and IO-mapped registers
module io_regfile
   import io_regfile_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   parameter  int NIO   = DEF_NIO,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic [AW-1:0]        addr_i,
   input  logic [WIDTH-1:0]     d_i,
   input  logic [AW-1:0]        cha_i,
   input  logic [AW-1:0]        chb_i,
   output logic [WIDTH-1:0]     da_o,
   output logic [WIDTH-1:0]     db_o,
   output logic [WIDTH-1:0]     b0_o,
   output logic [WIDTH-1:0]     b_last_o,
   inout  wire  [NIO*WIDTH-1:0] b_io,
   output logic [NIO-1:0]       chg_o
);

   logic [WIDTH-1:0] q_q [DEPTH];
   logic [WIDTH-1:0] q_d [DEPTH];
   logic [WIDTH-1:0] eff [DEPTH];
   logic [WIDTH-1:0] s2  [NIO];
   logic [WIDTH-1:0] da_q, da_d, db_q, db_d;
   logic [NIO-1:0]   chg_q, chg_d, en, s_diff;
   logic             bypass_ok;

   assign en = q_q[0][NIO-1:0];

   for (genvar i = 0; i < NIO; i++) begin : g_io
      io_sync2 #(.WIDTH(WIDTH)) u_sync (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .d_i      (b_io[i*WIDTH +: WIDTH]),
         .q_o      (s2[i]),
         .change_o (s_diff[i])
      );
      assign b_io[i*WIDTH +: WIDTH] = en[i] ? q_q[i+1] : {WIDTH{1'bz}};
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_eff
      if (k >= 1 && k <= NIO) begin : g_pin
         assign eff[k] = en[k-1] ? q_q[k] : s2[k-1];
      end else begin : g_reg
         assign eff[k] = q_q[k];
      end
   end

   always_comb begin
      q_d = q_q;
      if (we_i) q_d[addr_i] = d_i;

      // An input-mode IO register reads its pin, so a write to it must not bypass.
      bypass_ok = !io_input_mode(32'(addr_i), NIO, 64'(q_q[0]));
      da_d = (we_i && bypass_ok && (addr_i == cha_i)) ? d_i : eff[cha_i];
      db_d = (we_i && bypass_ok && (addr_i == chb_i)) ? d_i : eff[chb_i];

      chg_d = chg_q;
      for (int i = 0; i < NIO; i++) begin
         if (!en[i] && s_diff[i])                  chg_d[i] = 1'b1;
         else if (we_i && (addr_i == AW'(i + 1))) chg_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < DEPTH; k++) q_q[k] <= '0;
         da_q  <= '0;
         db_q  <= '0;
         chg_q <= '0;
      end else begin
         q_q   <= q_d;
         da_q  <= da_d;
         db_q  <= db_d;
         chg_q <= chg_d;
      end
   end

   assign da_o     = da_q;
   assign db_o     = db_q;
   assign b0_o     = q_q[0];
   assign b_last_o = q_q[DEPTH-1];
   assign chg_o    = chg_q;

endmodule

// File: tb/tb_io_regfile.sv
// tb/tb_io_regfile.sv - directed scoreboard bench for io_regfile (default and 16x8x4 builds)
module tb_io_regfile;
   import io_regfile_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        we0, we1;
   logic [1:0]  addr0, cha0, chb0;
   logic [2:0]  addr1, cha1, chb1;
   word_t       d0, da0, db0, b00, blast0;
   logic [15:0] d1, da1, db1, b01, blast1;
   logic [1:0]  chg0;
   logic [3:0]  chg1;
   wire  [15:0] bio0;
   wire  [63:0] bio1;

   logic [15:0] pin0;
   logic [1:0]  pin0_en;
   logic        pin1_en;

   assign bio0[7:0]   = pin0_en[0] ? pin0[7:0]  : 8'bz;
   assign bio0[15:8]  = pin0_en[1] ? pin0[15:8] : 8'bz;
   assign bio1[15:0]  = pin1_en ? 16'hC0DE : 16'bz;
   assign bio1[47:32] = pin1_en ? 16'hBEEF : 16'bz;

   io_regfile u_dut0 (
      .clk_i(clk), .rst_i(rst), .we_i(we0), .addr_i(addr0), .d_i(d0),
      .cha_i(cha0), .chb_i(chb0), .da_o(da0), .db_o(db0), .b0_o(b00),
      .b_last_o(blast0), .b_io(bio0), .chg_o(chg0)
   );

   io_regfile #(.WIDTH(16), .DEPTH(8), .NIO(4)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .we_i(we1), .addr_i(addr1), .d_i(d1),
      .cha_i(cha1), .chb_i(chb1), .da_o(da1), .db_o(db1), .b0_o(b01),
      .b_last_o(blast1), .b_io(bio1), .chg_o(chg1)
   );

   typedef struct {
      string       tag;
      int          mode;
      logic [15:0] ea;
      logic [15:0] eb;
   } sb_t;

   sb_t sb [$];
   int  n_chk = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s got=%h expected=%h", tag, obs, exp);
   endtask

   // mode 0: no read check, 1: check da, 2: check da and db
   task automatic cyc(input int dut, input logic w, input logic [2:0] a, input logic [15:0] dd,
                      input logic [2:0] ca, input logic [2:0] cb, input int mode,
                      input logic [15:0] ea, input logic [15:0] eb, input string tag);
      sb_t e;
      if (dut == 0) begin
         we0 = w; addr0 = a[1:0]; d0 = dd[7:0]; cha0 = ca[1:0]; chb0 = cb[1:0];
      end else begin
         we1 = w; addr1 = a; d1 = dd; cha1 = ca; chb1 = cb;
      end
      if (mode != 0) begin
         e.tag = tag; e.mode = mode; e.ea = ea; e.eb = eb;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      we0 = 1'b0;
      we1 = 1'b0;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, "_a"}, (dut == 0) ? {8'h00, da0} : da1, e.ea);
         if (e.mode == 2) chk({e.tag, "_b"}, (dut == 0) ? {8'h00, db0} : db1, e.eb);
      end
   endtask

   initial begin
      logic [15:0] exp1 [8];
      rst = 1'b1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; d0 = 0; d1 = 0;
      cha0 = 0; chb0 = 0; cha1 = 0; chb1 = 0;
      pin0 = 16'h0000; pin0_en = 2'b00; pin1_en = 1'b1;

      // Reset with a competing write: reset wins
      cyc(0, 1, 1, 'hFF, 1, 2, 2, 'h00, 'h00, "rst_dadb");
      chk("rst_b0", {8'h00, b00}, 16'h0000);
      chk("rst_blast", {8'h00, blast0}, 16'h0000);
      chk("rst_chg", {14'h0, chg0}, 16'h0000);
      rst = 1'b0;

      cyc(0, 1, 0, 'h03, 0, 0, 0, 0, 0, "");
      cyc(0, 1, 1, 'hA5, 0, 0, 0, 0, 0, "");
      cyc(0, 1, 2, 'h3C, 0, 0, 0, 0, 0, "");
      cyc(0, 1, 3, 'h77, 0, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0,    1, 2, 2, 'hA5, 'h3C, "rd12");
      chk("pin0_drv", {8'h00, bio0[7:0]}, 16'h00A5);
      chk("pin1_drv", {8'h00, bio0[15:8]}, 16'h003C);
      chk("blast", {8'h00, blast0}, 16'h0077);
      chk("b0", {8'h00, b00}, 16'h0003);

      cyc(0, 1, 3, 'h5A, 3, 3, 2, 'h5A, 'h5A, "bypass");
      chk("blast_new", {8'h00, blast0}, 16'h005A);

      // Input mode: pin lands in s1, then s2, then da
      cyc(0, 1, 0, 'h00, 0, 0, 0, 0, 0, "");
      pin0 = 16'h0081; pin0_en = 2'b01;
      cyc(0, 0, 0, 0, 1, 1, 1, 'hA5, 0, "in_e1");
      cyc(0, 0, 0, 0, 1, 1, 1, 'hA5, 0, "in_e2");
      chk("chg_set", {15'h0, chg0[0]}, 16'h0001);
      cyc(0, 0, 0, 0, 1, 1, 1, 'h81, 0, "in_e3");
      pin0 = 16'h0042;
      cyc(0, 0, 0, 0, 1, 1, 1, 'h81, 0, "in_e4");
      cyc(0, 1, 1, 'h00, 1, 1, 1, 'h81, 0, "in_nobyp");
      chk("chg_setwins", {15'h0, chg0[0]}, 16'h0001);
      cyc(0, 1, 1, 'h00, 1, 1, 1, 'h42, 0, "in_new");
      chk("chg_clr", {15'h0, chg0[0]}, 16'h0000);

      // Direction flip
      pin0 = 16'h000F;
      cyc(0, 1, 1, 'hF0, 0, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0,    0, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0,    1, 1, 1, 'h0F, 0, "flip_in");
      pin0_en = 2'b00;
      cyc(0, 1, 0, 'h01, 1, 1, 1, 'h0F, 0, "flip_old");
      cyc(0, 0, 0, 0,    1, 1, 1, 'hF0, 0, "flip_new");
      chk("flip_pin", {8'h00, bio0[7:0]}, 16'h00F0);

      // Reset mid-operation discards the concurrent write
      rst = 1'b1;
      cyc(0, 1, 1, 'hFF, 1, 2, 2, 'h00, 'h00, "rstmid");
      chk("rstmid_chg", {14'h0, chg0}, 16'h0000);
      chk("rstmid_b0", {8'h00, b00}, 16'h0000);
      rst = 1'b0;
      cyc(0, 1, 0, 'h01, 0, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0,    1, 1, 2, 'h00, 'h00, "rstmid_r1");
      chk("rstmid_pin", {8'h00, bio0[7:0]}, 16'h0000);

      // 16x8 build with mixed direction: regs 2,4 drive, regs 1,3 read pins
      rst = 1'b1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      rst = 1'b0;
      for (int k = 0; k < 8; k++)
         cyc(1, 1, 3'(k), (k == 0) ? 16'h000A : 16'(16'h1111 * k), 0, 0, 0, 0, 0, "");
      exp1 = '{16'h000A, 16'hC0DE, 16'h2222, 16'hBEEF, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
      for (int k = 0; k < 4; k++)
         cyc(1, 0, 0, 0, 3'(2*k), 3'(2*k+1), 2, exp1[2*k], exp1[2*k+1], "sweep");
      chk("sw_pin1", bio1[31:16], 16'h2222);
      chk("sw_pin3", bio1[63:48], 16'h4444);
      chk("sw_b0", b01, 16'h000A);
      chk("sw_blast", blast1, 16'h7777);
      cyc(1, 1, 3, 'hABCD, 3, 3, 2, 'hBEEF, 'hBEEF, "sw_nobyp");
      cyc(1, 1, 6, 'h9999, 6, 6, 2, 'h9999, 'h9999, "sw_byp");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
